// File: rtl/heater_ramp_ctrl.sv
// heater_ramp_ctrl: turns requested heater channels on one at a time with a dwell between them,
// and synchronizes/latches heater errors. Macro HEATER_RAMP_AUTO_TRIP_EN adds a global TRIP state.
module heater_ramp_ctrl #(
  parameter int Nchan  = 32,
  parameter int Ndwell = 1024,
  parameter int Ncnt   = 8
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic [Nchan-1:0] enable_req,
  input  logic [Nchan-1:0] err_clear,
  input  logic             cnt_clear,
  input  logic [Nchan-1:0] heater_error_in,
  output logic [Nchan-1:0] heater_enable,
  output logic [Nchan-1:0] err_sticky,
  output logic [Ncnt-1:0]  err_count,
  output logic             ramp_busy,
  output logic [1:0]       fsm_state
);

  localparam int CW = (Ndwell > 1) ? $clog2(Ndwell) : 1;
  localparam logic [CW-1:0]   DWELL_LOAD = CW'(Ndwell - 1);
  localparam logic [Ncnt-1:0] CNT_MAX    = '1;

`ifdef HEATER_RAMP_AUTO_TRIP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    TRIP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1
  } state_t;
`endif

  state_t            state_reg, state_next;
  logic [CW-1:0]     dwell_reg, dwell_next;
  logic [Nchan-1:0]  enable_reg, enable_next;
  logic [Nchan-1:0]  sticky_reg, sticky_next;
  logic [Ncnt-1:0]   count_reg, count_next;
  logic [Nchan-1:0]  rise;
  logic [Nchan-1:0]  pend;
  logic [Nchan-1:0]  first_pend;
  logic [Nchan-1:0]  turn_on;

  // Per channel: two synchronizer flops, then the edge register pair (cur/prev).
  for (genvar gi = 0; gi < Nchan; gi++) begin : g_err_sync
    logic sync1_reg;
    logic sync2_reg;
    logic cur_reg;
    logic prev_reg;

    always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        cur_reg   <= 1'b0;
        prev_reg  <= 1'b0;
      end else begin
        sync1_reg <= heater_error_in[gi];
        sync2_reg <= sync1_reg;
        cur_reg   <= sync2_reg;
        prev_reg  <= cur_reg;
      end
    end

    assign rise[gi] = cur_reg & ~prev_reg;
  end

  assign pend       = enable_req & ~enable_reg & ~sticky_reg;
  assign first_pend = pend & (~pend + Nchan'(1));

  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    turn_on    = '0;

    case (state_reg)
      IDLE: begin
        if (|pend) begin
          turn_on    = first_pend;
          dwell_next = DWELL_LOAD;
          state_next = DWELL;
        end
      end
      DWELL: begin
        if (dwell_reg == '0) begin
          state_next = IDLE;
        end else begin
          dwell_next = dwell_reg - CW'(1);
        end
      end
`ifdef HEATER_RAMP_AUTO_TRIP_EN
      TRIP: begin
        if (sticky_reg == '0) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // Turn-offs and faulted channels apply in every state; a fault beats a same-cycle turn-on.
    enable_next = ((enable_reg & enable_req) | turn_on) & ~rise;

`ifdef HEATER_RAMP_AUTO_TRIP_EN
    if (|rise) begin
      state_next  = TRIP;
      enable_next = '0;
    end else if (state_reg == TRIP) begin
      enable_next = '0;
    end
`endif

    sticky_next = (sticky_reg & ~err_clear) | rise;

    count_next = count_reg;
    if (cnt_clear) begin
      count_next = '0;
    end else if ((|rise) && (count_reg != CNT_MAX)) begin
      count_next = count_reg + Ncnt'(1);
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_reg  <= IDLE;
      dwell_reg  <= '0;
      enable_reg <= '0;
      sticky_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      dwell_reg  <= dwell_next;
      enable_reg <= enable_next;
      sticky_reg <= sticky_next;
      count_reg  <= count_next;
    end
  end

  assign heater_enable = enable_reg;
  assign err_sticky    = sticky_reg;
  assign err_count     = count_reg;
  assign fsm_state     = state_reg;
  assign ramp_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_heater_ramp_ctrl.sv
// tb_heater_ramp_ctrl: directed and randomized checks of heater_ramp_ctrl against a timing-level model.
// Honours HEATER_RAMP_AUTO_TRIP_EN when the same macro is given to the bench.
module tb_heater_ramp_ctrl;

  localparam int NCH = 8;
  localparam int NDW = 4;
  localparam int NCN = 2;
  localparam int CMAX = (1 << NCN) - 1;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NCH-1:0] req, eclr, ein;
  logic           cclr;
  logic [NCH-1:0] hen, stk;
  logic [NCN-1:0] cnt;
  logic           busy;
  logic [1:0]     st;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  heater_ramp_ctrl #(.Nchan(NCH), .Ndwell(NDW), .Ncnt(NCN)) dut (
    .axi_aclk(clk),
    .axi_aresetn(rstn),
    .enable_req(req),
    .err_clear(eclr),
    .cnt_clear(cclr),
    .heater_error_in(ein),
    .heater_enable(hen),
    .err_sticky(stk),
    .err_count(cnt),
    .ramp_busy(busy),
    .fsm_state(st)
  );

  // Reference model: error effect appears 3 edges after the input is sampled; a turn-on at edge m
  // keeps the controller busy until edge m+NDW, so the next turn-on is NDW+1 edges later.
  logic [NCH-1:0] m_hen = '0;
  logic [NCH-1:0] m_stk = '0;
  int             m_cnt = 0;
  logic [NCH-1:0] m_samp [4];
  int             m_edge = 0;
  int             m_busy_until = 0;
  bit             m_trip = 1'b0;

  function automatic logic [1:0] m_state();
    if (m_trip) return 2'd2;
    if (m_edge < m_busy_until) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] rise, pend, on, new_hen;
    m_edge++;
    if (!rstn) begin
      m_hen = '0; m_stk = '0; m_cnt = 0; m_trip = 1'b0;
      m_busy_until = m_edge;
      for (int i = 0; i < 4; i++) m_samp[i] = '0;
      return;
    end
    rise = m_samp[2] & ~m_samp[3];
    pend = req & ~m_hen & ~m_stk;
    on = '0;
    if (!m_trip && (m_edge - 1 >= m_busy_until) && (pend != '0)) begin
      for (int i = 0; i < NCH; i++) begin
        if (pend[i]) begin
          on[i] = 1'b1;
          break;
        end
      end
      m_busy_until = m_edge + NDW;
    end
    new_hen = ((m_hen & req) | on) & ~rise;
`ifdef HEATER_RAMP_AUTO_TRIP_EN
    if (rise != '0) begin
      m_trip = 1'b1;
      new_hen = '0;
    end else if (m_trip && (m_stk == '0)) begin
      m_trip = 1'b0;
      m_busy_until = m_edge;
    end else if (m_trip) begin
      new_hen = '0;
    end
`endif
    m_hen = new_hen;
    m_stk = (m_stk & ~eclr) | rise;
    if (cclr) m_cnt = 0;
    else if ((rise != '0) && (m_cnt < CMAX)) m_cnt = m_cnt + 1;
    m_samp[3] = m_samp[2];
    m_samp[2] = m_samp[1];
    m_samp[1] = m_samp[0];
    m_samp[0] = ein;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = '0; eclr = '0; ein = '0; cclr = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (hen !== '0 || stk !== '0 || cnt !== '0 || st !== 2'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: hen=%h stk=%h cnt=%0d st=%0d busy=%b, required all 0", hen, stk, cnt, st, busy);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_ramp();
    int n_on;
    logic [NCH-1:0] exp_hen;
    logic exp_busy;
    rstn = 1'b1;
    req = NCH'(8'h0F);
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_on = (k - 1) / 5 + 1;
      if (n_on > 4) n_on = 4;
      exp_hen = NCH'((1 << n_on) - 1);
      exp_busy = (k <= 19) && (((k - 1) % 5) < 4);
      tests_run++;
      if (hen !== exp_hen || busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL ramp cycle %0d: hen=%h busy=%b, required hen=%h busy=%b", k, hen, busy, exp_hen, exp_busy);
      end
      tests_run++;
      if ({hen, stk, cnt, st} !== {m_hen, m_stk, NCN'(m_cnt), m_state()}) begin
        tests_failed++;
        $display("FAIL ramp_model cycle %0d: hen=%h stk=%h cnt=%0d st=%0d, required %h %h %0d %0d",
                 k, hen, stk, cnt, st, m_hen, m_stk, m_cnt, m_state());
      end
    end
    $display("[TB] test_ramp done");
  endtask

  task automatic test_turnoff();
    req = NCH'(8'h05);
    tick();
    tests_run++;
    if (hen !== NCH'(8'h05) || st !== 2'd0) begin
      tests_failed++;
      $display("FAIL turnoff: hen=%h st=%0d, required hen=05 st=0", hen, st);
    end
    tick();
    tests_run++;
    if (st !== 2'd0 || hen !== NCH'(8'h05)) begin
      tests_failed++;
      $display("FAIL turnoff_idle: hen=%h st=%0d, required hen=05 st=0", hen, st);
    end
    $display("[TB] test_turnoff done");
  endtask

`ifndef HEATER_RAMP_AUTO_TRIP_EN
  task automatic test_error_sticky();
    ein[2] = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (stk !== '0 || hen !== NCH'(8'h05)) begin
      tests_failed++;
      $display("FAIL err_latency_early: stk=%h hen=%h, required stk=00 hen=05", stk, hen);
    end
    tick();
    tests_run++;
    if (stk !== NCH'(8'h04) || hen !== NCH'(8'h01) || cnt !== NCN'(1)) begin
      tests_failed++;
      $display("FAIL err_set: stk=%h hen=%h cnt=%0d, required stk=04 hen=01 cnt=1", stk, hen, cnt);
    end
    tick();
    ein[2] = 1'b0;
    repeat (6) tick();
    tests_run++;
    if (stk !== NCH'(8'h04) || hen !== NCH'(8'h01) || cnt !== NCN'(1)) begin
      tests_failed++;
      $display("FAIL err_hold: stk=%h hen=%h cnt=%0d, required stk=04 hen=01 cnt=1", stk, hen, cnt);
    end
    eclr[2] = 1'b1;
    tick();
    eclr[2] = 1'b0;
    tests_run++;
    if (stk !== '0 || hen !== NCH'(8'h01)) begin
      tests_failed++;
      $display("FAIL err_clear: stk=%h hen=%h, required stk=00 hen=01", stk, hen);
    end
    tick();
    tests_run++;
    if (hen !== NCH'(8'h05) || st !== 2'd1) begin
      tests_failed++;
      $display("FAIL err_reramp: hen=%h st=%0d, required hen=05 st=1", hen, st);
    end
    repeat (NDW + 1) tick();
    $display("[TB] test_error_sticky done");
  endtask

  task automatic test_set_clear_saturation();
    cclr = 1'b1;
    tick();
    cclr = 1'b0;
    tests_run++;
    if (cnt !== '0) begin
      tests_failed++;
      $display("FAIL cnt_clear_first: cnt=%0d, required 0", cnt);
    end
    ein[0] = 1'b1;
    repeat (3) tick();
    eclr[0] = 1'b1;
    tick();
    eclr[0] = 1'b0;
    tests_run++;
    if (stk !== NCH'(8'h01) || hen !== NCH'(8'h04) || cnt !== NCN'(1)) begin
      tests_failed++;
      $display("FAIL set_beats_clear: stk=%h hen=%h cnt=%0d, required stk=01 hen=04 cnt=1", stk, hen, cnt);
    end
    for (int p = 0; p < 5; p++) begin
      ein[3] = 1'b1;
      tick();
      ein[3] = 1'b0;
      tick();
      tick();
    end
    repeat (4) tick();
    tests_run++;
    if (cnt !== NCN'(CMAX) || stk !== NCH'(8'h09)) begin
      tests_failed++;
      $display("FAIL cnt_saturate: cnt=%0d stk=%h, required cnt=%0d stk=09", cnt, stk, CMAX);
    end
    cclr = 1'b1;
    tick();
    cclr = 1'b0;
    tests_run++;
    if (cnt !== '0) begin
      tests_failed++;
      $display("FAIL cnt_clear: cnt=%0d, required 0", cnt);
    end
    ein = '0;
    $display("[TB] test_set_clear_saturation done");
  endtask
`else
  task automatic test_auto_trip();
    ein = '0; req = '0; eclr = '1;
    repeat (6) tick();
    eclr = '0;
    repeat (NDW + 2) tick();
    req = NCH'(8'h0F);
    repeat (12) tick();
    ein[1] = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (hen !== '0 || st !== 2'd2 || stk !== NCH'(8'h02) || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL trip_enter: hen=%h st=%0d stk=%h busy=%b, required hen=00 st=2 stk=02 busy=1", hen, st, stk, busy);
    end
    ein[1] = 1'b0;
    eclr[1] = 1'b1;
    tick();
    eclr[1] = 1'b0;
    tick();
    tests_run++;
    if (st !== 2'd0 || hen !== '0) begin
      tests_failed++;
      $display("FAIL trip_exit: st=%0d hen=%h, required st=0 hen=00", st, hen);
    end
    tick();
    tests_run++;
    if (hen !== NCH'(8'h01) || st !== 2'd1) begin
      tests_failed++;
      $display("FAIL trip_reramp: hen=%h st=%0d, required hen=01 st=1", hen, st);
    end
    $display("[TB] test_auto_trip done");
  endtask
`endif

  task automatic test_random();
    int bad = 0;
    ein = '0; eclr = '1; cclr = 1'b0;
    repeat (5) tick();
    eclr = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) req = NCH'($urandom);
      if ($urandom_range(0, 9) == 0) ein = ein ^ NCH'(1 << $urandom_range(0, NCH - 1));
      eclr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      cclr = ($urandom_range(0, 31) == 0);
      tick();
      tests_run++;
      if ({hen, stk, cnt, st, busy} !== {m_hen, m_stk, NCN'(m_cnt), m_state(), m_state() != 2'd0}) begin
        tests_failed++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d: hen=%h stk=%h cnt=%0d st=%0d busy=%b, required %h %h %0d %0d",
                   c, hen, stk, cnt, st, busy, m_hen, m_stk, m_cnt, m_state());
      end
    end
    cclr = 1'b0;
    eclr = '0;
    $display("[TB] test_random done");
  endtask

  task automatic test_reset_mid_dwell();
    ein = '0; eclr = '1; req = '0;
    repeat (6) tick();
    eclr = '0;
    repeat (NDW + 2) tick();
    req = NCH'(8'h0F);
    repeat (2) tick();
    tests_run++;
    if (st !== 2'd1 || hen !== NCH'(8'h01)) begin
      tests_failed++;
      $display("FAIL middwell_setup: st=%0d hen=%h, required st=1 hen=01", st, hen);
    end
    rstn = 1'b0;
    tick();
    tests_run++;
    if (hen !== '0 || stk !== '0 || cnt !== '0 || st !== 2'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL middwell_reset: hen=%h stk=%h cnt=%0d st=%0d busy=%b, required all 0", hen, stk, cnt, st, busy);
    end
    rstn = 1'b1;
    tick();
    tests_run++;
    if (hen !== NCH'(8'h01) || st !== 2'd1 || hen !== m_hen) begin
      tests_failed++;
      $display("FAIL middwell_restart: hen=%h st=%0d, required hen=01 st=1", hen, st);
    end
    $display("[TB] test_reset_mid_dwell done");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_turnoff();
`ifndef HEATER_RAMP_AUTO_TRIP_EN
    test_error_sticky();
    test_set_clear_saturation();
`else
    test_auto_trip();
`endif
    test_random();
    test_reset_mid_dwell();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
